// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the word FIFO slice.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for word_fifo: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO with valid/ready on both ends; flags derive from the stored-word count.
module word_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("word_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] mem_rdata;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_valid && !full;
  assign pop   = rd_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Gate the write during reset so a push in the reset cycle leaves no trace.
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_rdata;
  assign count    = count_q;

endmodule

// File: tb/tb_word_fifo.sv
// Directed and randomized checks of word_fifo against a queue-based reference model.
module tb_word_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model[$];

  word_fifo #(
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model across the edge.
  task automatic step(input logic wv, input logic [31:0] wd, input logic rr, input logic rst);
    bit do_push, do_pop;
    int sz;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    reset    = rst;
    #1;
    sz = model.size();
    chk("count", 32'(count), 32'(sz));
    chk("wr_ready", {31'b0, wr_ready}, (sz < DEPTH) ? 32'd1 : 32'd0);
    chk("rd_valid", {31'b0, rd_valid}, (sz != 0) ? 32'd1 : 32'd0);
    chk("rd_data", rd_data, (sz != 0) ? model[0] : 32'd0);
    do_push = wv && (sz < DEPTH);
    do_pop  = rr && (sz > 0);
    @(posedge clk);
    if (rst) begin
      model.delete();
    end else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(wd);
    end
    #1;
  endtask

  initial begin
    int max_cnt;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);

    // Fill to full, then attempt a ninth push
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_wr_ready", {31'b0, wr_ready}, 32'd0);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("full_count_after_9th", 32'(count), 32'd8);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b0;
      #1;
      chk("drain_word", rd_data, 32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("drain_rd_data", rd_data, 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
      chk("sim_count", 32'(count), 32'd3);
    end
    while (model.size() != 0) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Pointer wrap, one push then one pop per value
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      chk("wrap_word", rd_data, 32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("wrap_max_count", 32'(max_cnt), 32'd1);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd5);
    step(1'b1, 32'hFFFF0000, 1'b1, 1'b1);
    chk("mid_reset_count", 32'(count), 32'd0);
    chk("mid_reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("mid_reset_wr_ready", {31'b0, wr_ready}, 32'd1);
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    chk("post_reset_word", rd_data, 32'h12345678);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end
    step(1'b0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/word_fifo.md
# word_fifo

Synchronous first-word-fall-through FIFO for 32-bit data words with valid/ready handshakes on both ends. It is the consumer-side companion to the team's 32-bit capture register: the register latches words, and this block buffers them and presents them in order to a downstream reader. All logic runs on a single clock domain.

## Interface

- Parameters
  - DATA_W, 32, word width in bits.
  - DEPTH, 8, number of entries; must be a power of two and at least 2.
- Ports
  - clk  input  1  clock; all state updates on the rising edge.
  - reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
  - wr_valid  input  1  writer presents wr_data.
  - wr_data  input  DATA_W  word to enqueue.
  - wr_ready  output  1  FIFO can accept a word; equals not full.
  - rd_valid  output  1  rd_data holds the oldest word; equals not empty.
  - rd_data  output  DATA_W  oldest stored word; forced to 0 when rd_valid=0.
  - rd_ready  input  1  reader accepts rd_data.
  - count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.

## Operation

- Push occurs when wr_valid && wr_ready at a rising edge. The word is written to mem[wr_ptr], and wr_ptr increments.
- Pop occurs when rd_valid && rd_ready at a rising edge. rd_ptr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. No modulo logic is needed because DEPTH is a power of two.
- count update per edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Flags are derived combinationally from count: full = (count == DEPTH), empty = (count == 0).
- There is no explicit state machine. State consists of wr_ptr, rd_ptr, count and the memory array.
- Boundary rules:
  - Full: wr_ready=0, so a push is impossible and wr_valid is ignored. A pop while full is allowed.
  - Empty: rd_valid=0 and rd_data=0. A pop is impossible. There is no write-to-read bypass, so a word written into an empty FIFO appears on the next cycle.
  - Simultaneous push and pop when 0 < count < DEPTH: both take effect and count is unchanged.
  - Push with pop when full cannot occur, because wr_ready=0.
  - Push with pop when empty cannot occur, because rd_valid=0.
- Reset, including mid-operation: wr_ptr=0, rd_ptr=0, count=0. Memory contents are not cleared. Any in-flight push or pop in the reset cycle is discarded.
- Inputs are not checked for X. Callers must not change wr_data while wr_valid=1 && wr_ready=0.

## Timing

- Output values after reset: wr_ready=1, rd_valid=0, rd_data=0, count=0.
- Write-to-read latency is 1 cycle. A word pushed at edge N is visible on rd_data with rd_valid=1 after edge N, provided it is at the head.
- rd_data is combinational from mem[rd_ptr] gated by rd_valid. It updates in the same cycle that rd_ptr changes.
- wr_ready and rd_valid depend only on registered state. There is no combinational path from wr_valid or rd_ready to any output.
- Throughput is one push and one pop per cycle.

## Structure

- Shared package fifo_pkg holds:
  - The DATA_W default constant (32).
  - A ptr_w(depth) function returning $clog2(depth).
- Sub-module fifo_mem holds the storage array:
  - Parameters: DATA_W and DEPTH.
  - One synchronous write port: we, waddr, wdata.
  - One asynchronous read port: raddr, rdata.
  - No reset.
- word_fifo contains the pointers, count, flag logic, rd_data gating, and one fifo_mem instance.
- A parameter assertion rejects DEPTH that is not a power of two or is less than 2.

## Test plan

- Reset check: hold reset=1 for 2 cycles, then release.
  - Required: wr_ready=1, rd_valid=0, rd_data=0, count=0.
- Fill to full: push 0x00000001..0x00000008 on 8 consecutive cycles with rd_ready=0.
  - Required: count=8 and wr_ready=0.
  - Then a 9th push of 0xDEADBEEF: count stays 8 and the word is never read out.
- Drain in order: with the FIFO full, hold rd_ready=1 for 8 cycles.
  - Required: rd_data sequence 1..8, then rd_valid=0, rd_data=0, count=0.
- Simultaneous push and pop: preload 3 words, then push 0xA5A5A5A5 while popping every cycle for 5 cycles.
  - Required: count holds at 3 throughout.
  - Required: output order is the 3 preloaded words followed by 0xA5A5A5A5 twice.
- Pointer wrap: run 20 pushes and 20 pops interleaved one-for-one with values 0..19.
  - Required: reads return 0..19 in order and count never exceeds 1.
- Reset mid-operation: with count=5, assert reset for 1 cycle while wr_valid=1 and rd_ready=1.
  - Required: next cycle count=0, rd_valid=0, wr_ready=1.
  - Required: a subsequent push of 0x12345678 is read back as 0x12345678.
